// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo bus: receiver byte input, consumer read port and status.
// master drives the receiver/consumer side, slave is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  uart_rec;
  logic [7:0]            uart_data_in;
  logic                  rd_req;
  logic                  overflow_clr;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  idle_timeout;

  modport master (
    output uart_rec, uart_data_in, rd_req, overflow_clr,
    input  rd_data, rd_valid, empty, full, count,
    input  overflow, idle_timeout
  );

  modport slave (
    input  uart_rec, uart_data_in, rd_req, overflow_clr,
    output rd_data, rd_valid, empty, full, count,
    output overflow, idle_timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected write, 1-cycle read, sticky overflow.
// Optional idle-line timeout pulse under UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int TIMEOUT_CYC = 1040
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_to
    $error("TIMEOUT_CYC out of range");
  end

  logic [7:0]            mem [DEPTH];
  logic                  rec_d;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic [DEPTH_LOG2:0]   cnt_nxt;
  logic [7:0]            rd_data_q;
  logic                  rd_valid_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  ovf_q;
  logic                  wr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  drop;

  assign wr     = bus.uart_rec & ~rec_d;
  assign rd_acc = bus.rd_req & ~empty_q;
  assign wr_acc = wr & (~full_q | rd_acc);
  assign drop   = wr & ~wr_acc;

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      wr_acc & ~rd_acc: cnt_nxt = cnt + 1'b1;
      ~wr_acc & rd_acc: cnt_nxt = cnt - 1'b1;
      default:          cnt_nxt = cnt;
    endcase
  end

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (wr_acc)
      mem[wptr] <= bus.uart_data_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rec_d      <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rec_d      <= bus.uart_rec;
      cnt        <= cnt_nxt;
      empty_q    <= (cnt_nxt == '0);
      full_q     <= (cnt_nxt == FULL_CNT);
      rd_valid_q <= rd_acc;
      if (wr_acc)
        wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rd_data_q <= mem[rptr];
        rptr      <= rptr + 1'b1;
      end
      if (drop)
        ovf_q <= 1'b1;
      else if (bus.overflow_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] to_cnt;
  logic        to_q;

  // Saturates at the limit so the pulse fires once per idle period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (wr_acc || empty_q) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (to_cnt != TO_LIM) begin
      to_cnt <= to_cnt + 1'b1;
      to_q   <= (to_cnt == TO_LIM - 1'b1);
    end else begin
      to_q   <= 1'b0;
    end
  end

  assign bus.idle_timeout = to_q;
`else
  assign bus.idle_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH_LOG2=4, TIMEOUT_CYC=20).
// Timeout expectations follow UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wcyc = 0;
  int pulse_cnt = 0;
  int pulse_all = 0;
  int pulse_cyc = 0;
  int maxc = 0;
  bit in_wrap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.idle_timeout === 1'b1) begin
      pulse_cnt++;
      pulse_all++;
      pulse_cyc = cyc;
    end
    if (in_wrap && int'(bus.count) > maxc)
      maxc = int'(bus.count);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_on(input logic [7:0] b, input logic rd);
    bus.uart_rec     = 1'b1;
    bus.uart_data_in = b;
    bus.rd_req       = rd;
    tick();
    wcyc       = cyc;
    bus.rd_req = 1'b0;
  endtask

  task automatic rec_off();
    repeat (12) tick();
    bus.uart_rec     = 1'b0;
    bus.uart_data_in = 8'h00;
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    rec_on(b, 1'b0);
    rec_off();
  endtask

  task automatic rd_one(output logic [7:0] d, output logic v);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    v = bus.rd_valid;
    d = bus.rd_data;
  endtask

  logic [7:0] d;
  logic       v;

  initial begin
    bus.uart_rec     = 1'b0;
    bus.uart_data_in = 8'h00;
    bus.rd_req       = 1'b0;
    bus.overflow_clr = 1'b0;

    repeat (3) tick();
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_overflow", 32'(bus.overflow), 32'h0);
    chk("rst_timeout", 32'(bus.idle_timeout), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    send(8'hA5);
    chk("single_count", 32'(bus.count), 32'h1);
    chk("single_empty", 32'(bus.empty), 32'h0);
    rd_one(d, v);
    chk("single_valid", 32'(v), 32'h1);
    chk("single_data", 32'(d), 32'hA5);
    chk("single_count0", 32'(bus.count), 32'h0);
    chk("single_empty1", 32'(bus.empty), 32'h1);
    tick();
    chk("single_pulse", 32'(bus.rd_valid), 32'h0);

    for (int i = 0; i < 16; i++) send(8'(i));
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_ovf0", 32'(bus.overflow), 32'h0);
    send(8'h10);
    chk("drop_ovf", 32'(bus.overflow), 32'h1);
    chk("drop_count", 32'(bus.count), 32'd16);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain_v%0d", i), 32'(bus.rd_valid), 32'h1);
      chk($sformatf("drain_d%0d", i), 32'(bus.rd_data), 32'(i));
    end
    bus.rd_req = 1'b0;
    tick();
    chk("drain_end_v", 32'(bus.rd_valid), 32'h0);
    chk("drain_empty", 32'(bus.empty), 32'h1);
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'h0);

    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    rec_on(8'h55, 1'b1);
    chk("fullrw_valid", 32'(bus.rd_valid), 32'h1);
    chk("fullrw_data", 32'(bus.rd_data), 32'h20);
    chk("fullrw_count", 32'(bus.count), 32'd16);
    chk("fullrw_ovf", 32'(bus.overflow), 32'h0);
    chk("fullrw_full", 32'(bus.full), 32'h1);
    rec_off();
    for (int i = 0; i < 16; i++) begin
      rd_one(d, v);
      chk($sformatf("fullrw_d%0d", i), 32'(d),
          (i == 15) ? 32'h55 : 32'(8'h21 + i));
    end
    chk("fullrw_empty", 32'(bus.empty), 32'h1);

    rd_one(d, v);
    chk("erd_valid", 32'(v), 32'h0);
    chk("erd_hold", 32'(d), 32'h55);
    rec_on(8'h3C, 1'b1);
    chk("erw_valid", 32'(bus.rd_valid), 32'h0);
    chk("erw_count", 32'(bus.count), 32'h1);
    rec_off();
    rd_one(d, v);
    chk("erw_rd_v", 32'(v), 32'h1);
    chk("erw_rd_d", 32'(d), 32'h3C);

    in_wrap = 1'b1;
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      send(8'(8'h80 + i));
      rd_one(d, v);
      chk($sformatf("wrap_d%0d", i), 32'(d), 32'(8'h80 + i));
    end
    in_wrap = 1'b0;
    chk("wrap_maxc", 32'(maxc), 32'h1);
    tick();

    pulse_cnt = 0;
    rec_on(8'h11, 1'b0);
    begin
      int w1;
      w1 = wcyc;
      rec_off();
      repeat (30) tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
      chk("to1_pulses", 32'(pulse_cnt), 32'h1);
      chk("to1_delay", 32'(pulse_cyc - w1), 32'd20);
`else
      chk("to1_pulses", 32'(pulse_cnt), 32'h0);
`endif
    end
    pulse_cnt = 0;
    rec_on(8'h22, 1'b0);
    begin
      int w2;
      w2 = wcyc;
      rec_off();
      repeat (30) tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
      chk("to2_pulses", 32'(pulse_cnt), 32'h1);
      chk("to2_delay", 32'(pulse_cyc - w2), 32'd20);
`else
      chk("to2_pulses", 32'(pulse_cnt), 32'h0);
      chk("to_never", 32'(pulse_all), 32'h0);
`endif
    end
    chk("to_count", 32'(bus.count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the high-speed UART receiver. It converts the receiver's multi-cycle `uart_rec` level into a single write strobe and stores each byte in a power-of-two FIFO. Consumers drain bytes through a one-cycle-latency read port. Status outputs are empty, full, fill count, sticky overflow and an optional idle-line timeout.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `TIMEOUT_CYC`, default 1040: idle cycles before `idle_timeout` fires, about 4 byte-times at 50 MHz / 2 Mbps. Legal range is 1..65535.
- `sys_clk` input 1: system clock; all logic runs on the rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `uart_rec` input 1: receiver "byte done" level; it stays high for several cycles per byte.
- `uart_data_in` input 8: receiver byte; valid while `uart_rec` is high, 0 otherwise.
- `rd_req` input 1: read request from the consumer.
- `rd_data` output 8: byte read out; valid when `rd_valid` is high.
- `rd_valid` output 1: one-cycle pulse marking `rd_data` valid.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds 2^DEPTH_LOG2 entries.
- `count` output DEPTH_LOG2+1: current fill level.
- `overflow` output 1: sticky flag, set when a byte is dropped.
- `overflow_clr` input 1: synchronous clear of `overflow`.
- `idle_timeout` output 1: one-cycle pulse; see Configuration.

## Operation
**Write strobe**
- A register `rec_d` holds `uart_rec` delayed by one cycle.
- `wr = uart_rec & ~rec_d`, so each byte produces exactly one write.
- `uart_data_in` is sampled in the `wr` cycle.

**Storage**
- Dual-pointer RAM with DEPTH_LOG2-bit `wptr` and `rptr`.
- Pointers wrap naturally from 2^DEPTH_LOG2-1 to 0.
- `count` is a separate up/down counter.

**Accepted read**
- A read is accepted when `rd_req` is high and `empty` is low.
- `rd_data` takes `mem[rptr]` on the next edge, `rd_valid` pulses for that cycle, and `rptr` advances.
- `rd_req` while empty is ignored: `rd_valid` stays 0 and `rd_data` holds its value.

**Accepted write**
- A write is accepted when `wr` is high and either `full` is low or a read is accepted in the same cycle.
- The byte is stored at `wptr` and `wptr` advances.

**Boundary cases**
- Write while full with no read: the byte is dropped, `overflow` is set and the pointers are unchanged.
- Write and read in the same cycle while full: both are performed, and `count` stays at the maximum.
- Write and read in the same cycle while empty: the write is performed, the read is ignored, and `count` becomes 1.
- Write and read in the same cycle otherwise: both are performed and `count` is unchanged.
- `overflow_clr` and a drop in the same cycle: set wins.
- `empty = (count == 0)` and `full = (count == 2^DEPTH_LOG2)`, both registered together with `count`.

## Timing
**Reset values (asynchronous)**
- `rd_data` = 0, `rd_valid` = 0, `empty` = 1, `full` = 0, `count` = 0, `overflow` = 0, `idle_timeout` = 0.
- Internally, the pointers, `rec_d` and the timeout counter are 0.
- Reset asserted mid-operation discards all contents. There is no partial-state recovery.

**Latency**
- Write to visibility: a byte written at edge N shows `empty` = 0 and an updated `count` after edge N.
- The byte can be requested in cycle N+1, so `rd_valid` comes at edge N+2 at the earliest.
- Read latency is 1 cycle from an accepted `rd_req` to `rd_valid`.
- Back-to-back `rd_req` drains one byte per cycle.

**Upstream assumptions**
- No handshake upstream: bytes arrive at most once per ~260 cycles.
- A `uart_rec` level already high when reset is released produces no write, because `rec_d` resets to 0. This is acceptable since the receiver also resets.

## Configuration
- `UART_RX_FIFO_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every accepted write and while `empty` is high.
  - Otherwise it increments, saturating at TIMEOUT_CYC.
  - `idle_timeout` pulses for one cycle on the transition to TIMEOUT_CYC.
  - The counter then holds, so there is no re-fire until the next write.
- `UART_RX_FIFO_TIMEOUT_EN` undefined: the counter is not built and `idle_timeout` is tied to 0.

## Test plan
- **Single byte:** hold `uart_rec` high 13 cycles with `uart_data_in` = 0xA5 → exactly one write; `count` = 1, `empty` = 0. Then `rd_req` → `rd_valid` is a 1-cycle pulse, `rd_data` = 0xA5, `count` = 0, `empty` = 1.
- **Fill and overflow:** write 0x00..0x0F with no reads → `full` = 1, `count` = 16. Write 0x10 → dropped and `overflow` = 1. Drain → data reads 0x00..0x0F in order. Pulse `overflow_clr` → `overflow` = 0.
- **Full plus simultaneous read/write:** at full, time `rd_req` with the write of 0x55 → `rd_data` = oldest byte, `count` stays 16, `overflow` stays 0, and 0x55 is read last.
- **Empty read and empty plus write:**
  - `rd_req` while empty → `rd_valid` stays 0.
  - `rd_req` coincident with a write of 0x3C while empty → read ignored, `count` = 1.
  - Next `rd_req` → `rd_data` = 0x3C.
- **Pointer wrap:** 40 write/read pairs with incrementing data → every byte is returned in order across the pointer wrap, and `count` never exceeds 1.
- **Timeout (macro defined, TIMEOUT_CYC = 20):** write one byte and do not read → `idle_timeout` pulses exactly once, 20 cycles after the write. A new write restarts the count. With the macro undefined, `idle_timeout` stays 0 throughout.
